decoder: RTL

//  64b66b -> XGMII RS decoder, RX mirror of the TX encoder (802.3 cl.49.2.11/49.2.13). Accepts 32-bit

---
 rtl/decoder_if.sv | 22 ++
 rtl/decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_if.sv
// Gearbox-to-decoder and decoder-to-MAC signal bundle.
// The master side drives the gearbox inputs; the slave side is the decoder.
interface decoder_if;
  logic [31:0] i_rxd;
  logic [1:0]  i_rx_header;
  logic        i_rx_valid;
  logic        i_frame_word;
  logic        i_block_lock;
  logic [31:0] o_rxd;
  logic [3:0]  o_rxctl;
  logic        o_rx_valid;

  modport master (
    output i_rxd, i_rx_header, i_rx_valid, i_frame_word, i_block_lock,
    input  o_rxd, o_rxctl, o_rx_valid
  );

  modport slave (
    input  i_rxd, i_rx_header, i_rx_valid, i_frame_word, i_block_lock,
    output o_rxd, o_rxctl, o_rx_valid
  );
endinterface

// File: rtl/decoder.sv
// 64b/66b receive decoder: rebuilds blocks from gearbox half-words, decodes them
// to XGMII, runs the receive framing state machine and emits 32-bit XGMII words.
module decoder #(
  parameter int OCODE_SUPPORT = 0
) (
  input  logic     i_rxc,
  input  logic     i_reset_n,
  decoder_if.slave bus
);
  localparam int DATA_WIDTH  = 32;
  localparam int DATA_NBYTES = DATA_WIDTH / 8;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTL  = 2'b01;

  localparam logic [7:0] BT_IDLE = 8'h1E, BT_O4 = 8'h2D, BT_S4 = 8'h33, BT_O0S4 = 8'h66;
  localparam logic [7:0] BT_O0O4 = 8'h55, BT_S0 = 8'h78, BT_O0 = 8'h4B;
  localparam logic [7:0] BT_T0 = 8'h87, BT_T1 = 8'h99, BT_T2 = 8'hAA, BT_T3 = 8'hB4;
  localparam logic [7:0] BT_T4 = 8'hCC, BT_T5 = 8'hD2, BT_T6 = 8'hE1, BT_T7 = 8'hFF;

  localparam logic [7:0] RS_IDLE = 8'h07, RS_START = 8'hFB, RS_TERM = 8'hFD;
  localparam logic [7:0] RS_ERROR = 8'hFE, RS_OSEQ = 8'h9C, RS_OSIG = 8'h5C;
  localparam logic [6:0] CC_IDLE = 7'h00;

  localparam logic [63:0] LBLOCK_DATA = 64'h0100_009C_0100_009C;
  localparam logic [7:0]  LBLOCK_CTL  = 8'h11;

  typedef enum logic [1:0] {RX_INIT, RX_C, RX_D, RX_E} rx_state_e;
  typedef enum logic [2:0] {CLS_C, CLS_S, CLS_T, CLS_D, CLS_E} blk_class_e;

  rx_state_e               state_q, state_d, prev_q, prev_d, step_state;
  logic [DATA_WIDTH-1:0]   lower_q, lower_d;
  logic [1:0]              hdr_q, hdr_d;
  logic                    have_lower_q, have_lower_d;
  logic [63:0]             hold_data_q, hold_data_d;
  logic [7:0]              hold_ctl_q, hold_ctl_d;
  logic [DATA_WIDTH-1:0]   rxd_q, rxd_d;
  logic [DATA_NBYTES-1:0]  rxctl_q, rxctl_d;
  logic                    rx_valid_q, rx_valid_d;

  logic [63:0]             blk, blk_shift;
  logic [7:0][7:0]         cc_char;
  logic [63:0]             dec_data;
  logic [7:0]              dec_ctl;
  blk_class_e              dec_class;
  logic [3:0]              t_len;

  assign blk       = {bus.i_rxd, lower_q};
  assign blk_shift = blk >> 8;

  // Every 7-bit control code sits at bit 8+7*lane in the block formats that carry them.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_cc
      assign cc_char[gi] = (blk[8+7*gi +: 7] == CC_IDLE) ? RS_IDLE : RS_ERROR;
    end
  endgenerate

  function automatic logic [7:0] ocode_char(input logic [3:0] ocode);
    if (ocode == 4'h0)      ocode_char = RS_OSEQ;
    else if (ocode == 4'hF) ocode_char = RS_OSIG;
    else                    ocode_char = RS_ERROR;
  endfunction

  always_comb begin
    dec_data  = {8{RS_ERROR}};
    dec_ctl   = 8'hFF;
    dec_class = CLS_E;
    t_len     = 4'd8;
    if (hdr_q == SYNC_DATA) begin
      dec_data  = blk;
      dec_ctl   = 8'h00;
      dec_class = CLS_D;
    end else if (hdr_q == SYNC_CTL) begin
      case (blk[7:0])
        BT_IDLE: begin
          dec_data  = cc_char;
          dec_class = CLS_C;
        end
        BT_S0: begin
          dec_data  = {blk[63:8], RS_START};
          dec_ctl   = 8'h01;
          dec_class = CLS_S;
        end
        BT_S4: begin
          dec_data  = {blk[63:40], RS_START, cc_char[3:0]};
          dec_ctl   = 8'h1F;
          dec_class = CLS_S;
        end
        BT_O4: if (OCODE_SUPPORT != 0) begin
          dec_data  = {blk[63:40], ocode_char(blk[39:36]), cc_char[3:0]};
          dec_ctl   = 8'h1F;
          dec_class = CLS_C;
        end
        BT_O0: if (OCODE_SUPPORT != 0) begin
          dec_data  = {cc_char[7:4], blk[31:8], ocode_char(blk[35:32])};
          dec_ctl   = 8'hF1;
          dec_class = CLS_C;
        end
        BT_O0O4: if (OCODE_SUPPORT != 0) begin
          dec_data  = {blk[63:40], ocode_char(blk[39:36]), blk[31:8], ocode_char(blk[35:32])};
          dec_ctl   = 8'h11;
          dec_class = CLS_C;
        end
        BT_O0S4: if (OCODE_SUPPORT != 0) begin
          dec_data  = {blk[63:40], RS_START, blk[31:8], ocode_char(blk[35:32])};
          dec_ctl   = 8'h11;
          dec_class = CLS_S;
        end
        BT_T0: t_len = 4'd0;
        BT_T1: t_len = 4'd1;
        BT_T2: t_len = 4'd2;
        BT_T3: t_len = 4'd3;
        BT_T4: t_len = 4'd4;
        BT_T5: t_len = 4'd5;
        BT_T6: t_len = 4'd6;
        BT_T7: t_len = 4'd7;
        default: ;
      endcase
      // Terminate blocks: data bytes follow the type byte, then /T/, then idles.
      if (t_len != 4'd8) begin
        dec_class = CLS_T;
        for (int i = 0; i < 8; i++) begin
          if (4'(i) < t_len) begin
            dec_data[8*i +: 8] = blk_shift[8*i +: 8];
            dec_ctl[i]         = 1'b0;
          end else if (4'(i) == t_len) begin
            dec_data[8*i +: 8] = RS_TERM;
          end else begin
            dec_data[8*i +: 8] = RS_IDLE;
          end
        end
      end
    end
  end

  always_comb begin
    step_state = RX_E;
    case (state_q)
      RX_INIT, RX_C: begin
        if (dec_class == CLS_C)      step_state = RX_C;
        else if (dec_class == CLS_S) step_state = RX_D;
      end
      RX_D: begin
        if (dec_class == CLS_D)      step_state = RX_D;
        else if (dec_class == CLS_T) step_state = RX_C;
      end
      RX_E: begin
        if (dec_class == CLS_C)                           step_state = RX_C;
        else if (dec_class == CLS_S)                      step_state = RX_D;
        else if (dec_class == CLS_D && prev_q == RX_D)    step_state = RX_D;
      end
      default: step_state = RX_E;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    lower_d      = lower_q;
    hdr_d        = hdr_q;
    have_lower_d = have_lower_q;
    hold_data_d  = hold_data_q;
    hold_ctl_d   = hold_ctl_q;
    rxd_d        = rxd_q;
    rxctl_d      = rxctl_q;
    rx_valid_d   = bus.i_rx_valid;
    if (bus.i_rx_valid) begin
      if (!bus.i_frame_word) begin
        rxd_d        = hold_data_q[31:0];
        rxctl_d      = hold_ctl_q[3:0];
        lower_d      = bus.i_rxd;
        hdr_d        = bus.i_rx_header;
        have_lower_d = bus.i_block_lock;
      end else begin
        rxd_d        = hold_data_q[63:32];
        rxctl_d      = hold_ctl_q[7:4];
        have_lower_d = 1'b0;
        prev_d       = state_q;
        // No lock, or an upper half with no matching lower half: resynchronise.
        if (!bus.i_block_lock || !have_lower_q) begin
          state_d     = RX_INIT;
          hold_data_d = LBLOCK_DATA;
          hold_ctl_d  = LBLOCK_CTL;
        end else begin
          state_d = step_state;
          if (step_state == RX_E) begin
            hold_data_d = {8{RS_ERROR}};
            hold_ctl_d  = 8'hFF;
          end else begin
            hold_data_d = dec_data;
            hold_ctl_d  = dec_ctl;
          end
        end
      end
    end
  end

  always_ff @(posedge i_rxc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= RX_INIT;
      prev_q       <= RX_INIT;
      lower_q      <= '0;
      hdr_q        <= '0;
      have_lower_q <= 1'b0;
      hold_data_q  <= {8{RS_IDLE}};
      hold_ctl_q   <= 8'hFF;
      rxd_q        <= {DATA_NBYTES{RS_IDLE}};
      rxctl_q      <= '1;
      rx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      lower_q      <= lower_d;
      hdr_q        <= hdr_d;
      have_lower_q <= have_lower_d;
      hold_data_q  <= hold_data_d;
      hold_ctl_q   <= hold_ctl_d;
      rxd_q        <= rxd_d;
      rxctl_q      <= rxctl_d;
      rx_valid_q   <= rx_valid_d;
    end
  end

  assign bus.o_rxd      = rxd_q;
  assign bus.o_rxctl    = rxctl_q;
  assign bus.o_rx_valid = rx_valid_q;
endmodule
